// File: rtl/int_entry_seq_pkg.sv
// Shared definitions for the interrupt entry/return sequencer.
package int_entry_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        VECTOR = 2'd2,
        RETURN = 2'd3
    } seqState_t;

    localparam int DEF_PC_WIDTH    = 16;
    localparam int DEF_STACK_DEPTH = 4;
    localparam int DEF_LVL_WIDTH   = 3;

endpackage

// File: rtl/int_entry_seq_ret_addr_stack.sv
// Return-address LIFO: push writes at count, pop exposes the entry at count-1 on dout.
module ret_addr_stack
    import int_entry_seq_pkg::*;
#(
    parameter int pcWidth    = DEF_PC_WIDTH,
    parameter int stackDepth = DEF_STACK_DEPTH,
    parameter int cntWidth   = DEF_LVL_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  logic                pop,
    input  logic [pcWidth-1:0]  din,
    output logic [pcWidth-1:0]  dout,
    output logic                full,
    output logic                empty,
    output logic [cntWidth-1:0] count
);

    localparam int addrW = (stackDepth > 1) ? $clog2(stackDepth) : 1;
    localparam logic [cntWidth-1:0] depthC = cntWidth'(stackDepth);

    logic [pcWidth-1:0] mem [stackDepth];
    logic [addrW-1:0]   wrIdx;
    logic [addrW-1:0]   rdIdx;

    assign wrIdx = addrW'(count);
    assign rdIdx = addrW'(count - cntWidth'(1));
    assign full  = (count == depthC);
    assign empty = (count == '0);
    assign dout  = mem[rdIdx];

    // Count saturates at both ends so the nesting level can never wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (push && !full) begin
            count <= count + cntWidth'(1);
        end else if (pop && !empty) begin
            count <= count - cntWidth'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wrIdx] <= din;
        end
    end

endmodule

// File: rtl/int_entry_seq.sv
// CPU-side interrupt entry/return sequencer: arms on a pending interrupt, vectors at an
// instruction boundary while saving the return PC, and restores it on return-from-interrupt.
module int_entry_seq
    import int_entry_seq_pkg::*;
#(
    parameter int pcWidth    = DEF_PC_WIDTH,
    parameter int stackDepth = DEF_STACK_DEPTH,
    parameter int lvlWidth   = DEF_LVL_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                intPending,
    input  logic [pcWidth-1:0]  intAddr,
    input  logic                gie,
    input  logic                instrDone,
    input  logic [pcWidth-1:0]  pc,
    input  logic                rti,
    output logic                intDisable,
    output logic                pendClr,
    output logic                pcLoad,
    output logic [pcWidth-1:0]  pcLoadVal,
    output logic                stall,
    output logic [lvlWidth-1:0] nestLevel,
    output logic                stackErr
);

    seqState_t          state;
    logic               rtiEv;
    logic               pushReq;
    logic               popReq;
    logic               stkFull;
    logic               stkEmpty;
    logic [pcWidth-1:0] stkDout;

    always_comb begin
        rtiEv   = instrDone & rti;
        pushReq = 1'b0;
        popReq  = 1'b0;
        case (state)
            IDLE: popReq = rtiEv & !stkEmpty;
            ARM: begin
                popReq  = rtiEv & !stkEmpty;
                pushReq = intPending & gie & instrDone & !rti & !stkFull;
            end
            default: ;
        endcase
    end

    ret_addr_stack #(
        .pcWidth    (pcWidth),
        .stackDepth (stackDepth),
        .cntWidth   (lvlWidth)
    ) uStack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (pushReq),
        .pop   (popReq),
        .din   (pc),
        .dout  (stkDout),
        .full  (stkFull),
        .empty (stkEmpty),
        .count (nestLevel)
    );

    // Strobes are set on the transition edge so they are high exactly while in VECTOR/RETURN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            intDisable <= 1'b0;
            pendClr    <= 1'b0;
            pcLoad     <= 1'b0;
            pcLoadVal  <= '0;
            stall      <= 1'b0;
            stackErr   <= 1'b0;
        end else begin
            pcLoad  <= 1'b0;
            pendClr <= 1'b0;
            stall   <= 1'b0;
            case (state)
                IDLE: begin
                    if (rtiEv) begin
                        if (!stkEmpty) begin
                            state     <= RETURN;
                            pcLoad    <= 1'b1;
                            pcLoadVal <= stkDout;
                            stall     <= 1'b1;
                        end else begin
                            stackErr <= 1'b1;
                        end
                    end else if (intPending && gie && !stkFull) begin
                        state      <= ARM;
                        intDisable <= 1'b1;
                    end
                end
                ARM: begin
                    if (rtiEv) begin
                        // Return wins; the pending interrupt is re-arbitrated from IDLE later.
                        intDisable <= 1'b0;
                        if (!stkEmpty) begin
                            state     <= RETURN;
                            pcLoad    <= 1'b1;
                            pcLoadVal <= stkDout;
                            stall     <= 1'b1;
                        end else begin
                            state    <= IDLE;
                            stackErr <= 1'b1;
                        end
                    end else if (!intPending || !gie) begin
                        state      <= IDLE;
                        intDisable <= 1'b0;
                    end else if (instrDone) begin
                        state     <= VECTOR;
                        pcLoad    <= 1'b1;
                        pcLoadVal <= intAddr;
                        pendClr   <= 1'b1;
                        stall     <= 1'b1;
                    end
                end
                VECTOR: begin
                    state      <= IDLE;
                    intDisable <= 1'b0;
                end
                RETURN: state <= IDLE;
                default: begin
                    state      <= IDLE;
                    intDisable <= 1'b0;
                end
            endcase
        end
    end

endmodule
